// File: rtl/dmi_arb_pkg.sv
// Shared types and constants for the two-requester DMI arbiter.
// Field layout: req = {addr[40:34], data[33:2], op[1:0]}, resp = {data[33:2], resp[1:0]}.
package dmi_arb_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REQ_W  = 41;
   localparam int unsigned RESP_W = 34;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   localparam logic [1:0] RESP_SUCCESS = 2'd0;
   localparam logic [1:0] RESP_FAILED  = 2'd2;
   localparam logic [1:0] RESP_BUSY    = 2'd3;

   localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hdeadbeef;

   typedef logic [REQ_W-1:0]  dmi_req_t;
   typedef logic [RESP_W-1:0] dmi_resp_t;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_REQ     = 3'd1;
   localparam state_t ST_RESP    = 3'd2;
   localparam state_t ST_DELIVER = 3'd3;
   localparam state_t ST_DRAIN   = 3'd4;

endpackage

// File: rtl/dmi_arbiter_rr_arb2.sv
// Two-input round-robin grant: purely combinational, shared with the bridge mux.
// On contention the rr pointer (0=A, 1=B) picks the winner.
module dmi_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       rr,
   output logic [1:0] gnt,
   output logic       idx
);

   assign idx = (valid == 2'b11) ? rr : valid[1];
   assign gnt = {idx, ~idx} & {2{|valid}};

endmodule

// File: rtl/dmi_arbiter.sv
// Shares the core-side DMI channel between the JTAG DTM (A) and a debug bridge (B).
// Optional response timeout enabled with `define DMI_ARB_TIMEOUT_EN.
module dmi_arbiter
   import dmi_arb_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic [REQ_W-1:0]  a_req_i,
   input  logic              a_req_valid_i,
   output logic              a_req_ready_o,
   output logic [RESP_W-1:0] a_resp_o,
   output logic              a_resp_valid_o,
   input  logic              a_resp_ready_i,
   input  logic [REQ_W-1:0]  b_req_i,
   input  logic              b_req_valid_i,
   output logic              b_req_ready_o,
   output logic [RESP_W-1:0] b_resp_o,
   output logic              b_resp_valid_o,
   input  logic              b_resp_ready_i,
   output logic [REQ_W-1:0]  dm_req_o,
   output logic              dm_req_valid_o,
   input  logic              dm_req_ready_i,
   input  logic [RESP_W-1:0] dm_resp_i,
   input  logic              dm_resp_valid_i,
   output logic              dm_resp_ready_o,
   output logic              busy_o,
   output logic              owner_o
);

   if (TimeoutCycles < 2 || CntWidth < 1) begin : g_bad_cfg
      $error("dmi_arbiter: TimeoutCycles must be >= 2");
   end

   state_t    state_q, state_d;
   logic      rr_q, rr_d;
   logic      owner_q, owner_d;
   dmi_req_t  req_q, req_d;
   dmi_resp_t resp_q, resp_d;
   logic      dm_req_valid_q, dm_resp_ready_q;
   logic      a_resp_valid_q, b_resp_valid_q, busy_q;

   logic [1:0] gnt;
   logic       win_idx;
   logic       grant_en, req_fire, dm_resp_fire, owner_resp_ready;
   logic       stale, stale_next, timeout;

   dmi_rr_arb2 u_arb (
      .valid ({b_req_valid_i, a_req_valid_i}),
      .rr    (rr_q),
      .gnt   (gnt),
      .idx   (win_idx)
   );

   assign grant_en         = (state_q == ST_IDLE) && !clear_i && !stale;
   assign a_req_ready_o    = grant_en & gnt[0];
   assign b_req_ready_o    = grant_en & gnt[1];
   assign req_fire         = grant_en & (|gnt);
   assign dm_resp_fire     = dm_resp_valid_i & dm_resp_ready_q;
   assign owner_resp_ready = owner_q ? b_resp_ready_i : a_resp_ready_i;

`ifdef DMI_ARB_TIMEOUT_EN
   logic                stale_q;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   assign stale   = stale_q;
   assign timeout = (state_q == ST_RESP) && !dm_resp_valid_i &&
                    (cnt_q == CntWidth'(TimeoutCycles - 1));

   // A late response after a timeout is swallowed here, never forwarded.
   always_comb begin
      stale_next = stale_q;
      if (clear_i)                      stale_next = 1'b0;
      else if (timeout)                 stale_next = 1'b1;
      else if (stale_q && dm_resp_fire) stale_next = 1'b0;

      cnt_d = cnt_q;
      if (state_q == ST_REQ)       cnt_d = '0;
      else if (state_q == ST_RESP) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stale_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         stale_q <= stale_next;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign stale      = 1'b0;
   assign stale_next = 1'b0;
   assign timeout    = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      req_d   = req_q;
      resp_d  = resp_q;
      case (state_q)
         ST_IDLE: begin
            if (req_fire) begin
               req_d   = win_idx ? b_req_i : a_req_i;
               owner_d = win_idx;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (clear_i)             state_d = ST_IDLE;
            else if (dm_req_ready_i) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (clear_i) begin
               state_d = ST_DRAIN;
            end else if (dm_resp_fire) begin
               resp_d  = dm_resp_i;
               state_d = ST_DELIVER;
            end else if (timeout) begin
               resp_d  = {TIMEOUT_DATA, RESP_FAILED};
               state_d = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            if (clear_i) begin
               state_d = ST_IDLE;
            end else if (owner_resp_ready) begin
               rr_d    = ~owner_q;
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (dm_resp_fire && !clear_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output flags are registered from the next-state decode so they align with state_q.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_i) begin
         state_q         <= ST_IDLE;
         rr_q            <= 1'b0;
         owner_q         <= 1'b0;
         req_q           <= '0;
         resp_q          <= '0;
         dm_req_valid_q  <= 1'b0;
         dm_resp_ready_q <= 1'b0;
         a_resp_valid_q  <= 1'b0;
         b_resp_valid_q  <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         rr_q            <= rr_d;
         owner_q         <= owner_d;
         req_q           <= req_d;
         resp_q          <= resp_d;
         dm_req_valid_q  <= (state_d == ST_REQ);
         dm_resp_ready_q <= (state_d == ST_RESP) || (state_d == ST_DRAIN) || stale_next;
         a_resp_valid_q  <= (state_d == ST_DELIVER) && !owner_d;
         b_resp_valid_q  <= (state_d == ST_DELIVER) && owner_d;
         busy_q          <= (state_d != ST_IDLE);
      end
   end

   assign dm_req_o        = req_q;
   assign dm_req_valid_o  = dm_req_valid_q;
   assign dm_resp_ready_o = dm_resp_ready_q;
   assign a_resp_o        = resp_q;
   assign b_resp_o        = resp_q;
   assign a_resp_valid_o  = a_resp_valid_q;
   assign b_resp_valid_o  = b_resp_valid_q;
   assign busy_o          = busy_q;
   assign owner_o         = owner_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: directed scenarios with random payloads,
// checked against a transaction-level round-robin model.
module tb_dmi_arbiter;
   import dmi_arb_pkg::*;

   localparam int TO = 16;

   logic              clk_i = 1'b0;
   logic              rst_i, clear_i;
   logic [REQ_W-1:0]  a_req_i, b_req_i, dm_req_o;
   logic              a_req_valid_i, a_req_ready_o, b_req_valid_i, b_req_ready_o;
   logic [RESP_W-1:0] a_resp_o, b_resp_o, dm_resp_i;
   logic              a_resp_valid_o, a_resp_ready_i, b_resp_valid_o, b_resp_ready_i;
   logic              dm_req_valid_o, dm_req_ready_i, dm_resp_valid_i, dm_resp_ready_o;
   logic              busy_o, owner_o;

   int checks = 0;
   int errors = 0;
   bit rr_m;   // model: who wins the next contended grant (0=A, 1=B)

   always #5 clk_i = ~clk_i;

   dmi_arbiter #(.TimeoutCycles(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
      .a_req_i(a_req_i), .a_req_valid_i(a_req_valid_i), .a_req_ready_o(a_req_ready_o),
      .a_resp_o(a_resp_o), .a_resp_valid_o(a_resp_valid_o), .a_resp_ready_i(a_resp_ready_i),
      .b_req_i(b_req_i), .b_req_valid_i(b_req_valid_i), .b_req_ready_o(b_req_ready_o),
      .b_resp_o(b_resp_o), .b_resp_valid_o(b_resp_valid_o), .b_resp_ready_i(b_resp_ready_i),
      .dm_req_o(dm_req_o), .dm_req_valid_o(dm_req_valid_o), .dm_req_ready_i(dm_req_ready_i),
      .dm_resp_i(dm_resp_i), .dm_resp_valid_i(dm_resp_valid_i), .dm_resp_ready_o(dm_resp_ready_o),
      .busy_o(busy_o), .owner_o(owner_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [REQ_W-1:0] rand_req();
      logic [6:0]  addr = 7'($urandom);
      logic [31:0] data = $urandom;
      logic [1:0]  op   = 2'($urandom_range(0, 2));
      return {addr, data, op};
   endfunction

   function automatic logic [RESP_W-1:0] rand_resp();
      logic [31:0] data = $urandom;
      logic [1:0]  rsp  = 2'($urandom_range(0, 3));
      return {data, rsp};
   endfunction

   task automatic do_reset();
      rst_i = 1'b1; clear_i = 1'b0;
      a_req_valid_i = 1'b0; b_req_valid_i = 1'b0;
      a_req_i = '0; b_req_i = '0; dm_resp_i = '0;
      dm_req_ready_i = 1'b0; dm_resp_valid_i = 1'b0;
      a_resp_ready_i = 1'b0; b_resp_ready_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;
      rr_m = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 64'(busy_o), 64'(0));
      chk({tag, "_dm_req_valid"}, 64'(dm_req_valid_o), 64'(0));
      chk({tag, "_a_resp_valid"}, 64'(a_resp_valid_o), 64'(0));
      chk({tag, "_b_resp_valid"}, 64'(b_resp_valid_o), 64'(0));
   endtask

   // Grant from IDLE through REQ; returns in the first RESP cycle.
   task automatic start(input int req_wait, output bit w);
      logic [REQ_W-1:0] exp_req;
      dm_req_ready_i = 1'b0;
      w = (a_req_valid_i && b_req_valid_i) ? rr_m : b_req_valid_i;
      exp_req = w ? b_req_i : a_req_i;
      #1;
      chk("grant_a_ready", 64'(a_req_ready_o), 64'(!w));
      chk("grant_b_ready", 64'(b_req_ready_o), 64'(w));
      chk("idle_dm_req_valid", 64'(dm_req_valid_o), 64'(0));
      tick();
      if (w) b_req_valid_i = 1'b0; else a_req_valid_i = 1'b0;
      chk("req_valid", 64'(dm_req_valid_o), 64'(1));
      chk("req_data", 64'(dm_req_o), 64'(exp_req));
      chk("req_owner", 64'(owner_o), 64'(w));
      chk("req_busy", 64'(busy_o), 64'(1));
      repeat (req_wait) begin
         tick();
         chk("req_hold_valid", 64'(dm_req_valid_o), 64'(1));
         chk("req_hold_data", 64'(dm_req_o), 64'(exp_req));
         chk("req_hold_readies", 64'({a_req_ready_o, b_req_ready_o}), 64'(0));
      end
      dm_req_ready_i = 1'b1;
      tick();
      dm_req_ready_i = 1'b0;
      chk("resp_dm_req_valid", 64'(dm_req_valid_o), 64'(0));
      chk("resp_dm_resp_ready", 64'(dm_resp_ready_o), 64'(1));
   endtask

   // DM response, delivery to the owner, and completion back to IDLE.
   task automatic finish(input bit w, input int resp_wait, input int rsp_wait,
                         input logic [RESP_W-1:0] data);
      repeat (resp_wait) begin
         tick();
         chk("resp_wait_resp_valids", 64'({a_resp_valid_o, b_resp_valid_o}), 64'(0));
         chk("resp_wait_dm_ready", 64'(dm_resp_ready_o), 64'(1));
      end
      dm_resp_valid_i = 1'b1;
      dm_resp_i = data;
      tick();
      dm_resp_valid_i = 1'b0;
      dm_resp_i = rand_resp();
      for (int k = 0; k <= rsp_wait; k++) begin
         if (k > 0) tick();
         chk("deliver_own_valid", 64'(w ? b_resp_valid_o : a_resp_valid_o), 64'(1));
         chk("deliver_other_valid", 64'(w ? a_resp_valid_o : b_resp_valid_o), 64'(0));
         chk("deliver_data", 64'(w ? b_resp_o : a_resp_o), 64'(data));
         chk("deliver_dm_resp_ready", 64'(dm_resp_ready_o), 64'(0));
         chk("deliver_readies", 64'({a_req_ready_o, b_req_ready_o}), 64'(0));
      end
      if (w) b_resp_ready_i = 1'b1; else a_resp_ready_i = 1'b1;
      tick();
      a_resp_ready_i = 1'b0;
      b_resp_ready_i = 1'b0;
      rr_m = !w;
      chk_idle("done");
   endtask

   task automatic serve(input int req_wait, input int resp_wait, input int rsp_wait);
      bit w;
      start(req_wait, w);
      finish(w, resp_wait, rsp_wait, rand_resp());
   endtask

   initial begin
      bit w;
      int n;

      // Reset state
      do_reset();
      chk_idle("rst");
      chk("rst_owner", 64'(owner_o), 64'(0));
      chk("rst_dm_resp_ready", 64'(dm_resp_ready_o), 64'(0));
      chk("rst_dm_req", 64'(dm_req_o), 64'(0));
      chk("rst_a_resp", 64'(a_resp_o), 64'(0));

      // Single read from A
      a_req_i = {7'h11, 32'h0, 2'h1};
      a_req_valid_i = 1'b1;
      start(0, w);
      finish(w, 2, 0, {32'h12345678, 2'h0});

      // Contention after reset, then alternating grants with both held valid
      do_reset();
      a_req_i = rand_req(); b_req_i = rand_req();
      a_req_valid_i = 1'b1; b_req_valid_i = 1'b1;
      serve(0, 0, 0);
      serve(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         if (!a_req_valid_i) begin a_req_i = rand_req(); a_req_valid_i = 1'b1; end
         if (!b_req_valid_i) begin b_req_i = rand_req(); b_req_valid_i = 1'b1; end
         serve($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      // Backpressure on both sides while B waits
      if (!b_req_valid_i) begin b_req_i = rand_req(); b_req_valid_i = 1'b1; end
      serve(5, 1, 4);
      serve(0, 0, 0);

      // clear_i in RESP: response drained, rr pointer untouched
      a_req_i = rand_req(); a_req_valid_i = 1'b1;
      start(0, w);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("drain_dm_resp_ready", 64'(dm_resp_ready_o), 64'(1));
      chk("drain_busy", 64'(busy_o), 64'(1));
      repeat (5) begin
         tick();
         chk("drain_resp_valids", 64'({a_resp_valid_o, b_resp_valid_o}), 64'(0));
      end
      dm_resp_valid_i = 1'b1; dm_resp_i = rand_resp();
      tick();
      dm_resp_valid_i = 1'b0;
      chk_idle("drained");
      a_req_i = rand_req(); b_req_i = rand_req();
      a_req_valid_i = 1'b1; b_req_valid_i = 1'b1;
      serve(0, 0, 0);
      serve(0, 0, 0);

      // Reset mid-REQ with the pointer on B
      a_req_i = rand_req(); a_req_valid_i = 1'b1;
      serve(0, 0, 0);
      a_req_i = rand_req(); a_req_valid_i = 1'b1;
      tick();
      a_req_valid_i = 1'b0;
      chk("pre_rst_req_valid", 64'(dm_req_valid_o), 64'(1));
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      rr_m = 1'b0;
      chk_idle("mid_rst");
      chk("mid_rst_owner", 64'(owner_o), 64'(0));
      a_req_i = rand_req(); b_req_i = rand_req();
      a_req_valid_i = 1'b1; b_req_valid_i = 1'b1;
      serve(0, 0, 0);
      serve(0, 0, 0);

      // clear_i in IDLE blocks the grant for that cycle
      a_req_i = rand_req(); a_req_valid_i = 1'b1; clear_i = 1'b1;
      #1;
      chk("clear_idle_ready", 64'(a_req_ready_o), 64'(0));
      tick();
      clear_i = 1'b0;
      chk("clear_idle_busy", 64'(busy_o), 64'(0));
      serve(0, 0, 0);

`ifdef DMI_ARB_TIMEOUT_EN
      // Silent DM: synthetic error, then grants held off until the late response
      a_req_i = rand_req(); a_req_valid_i = 1'b1;
      start(0, w);
      n = 0;
      for (int c = 1; c <= TO + 4; c++) begin
         tick();
         if (a_resp_valid_o) begin n = c; break; end
      end
      chk("timeout_latency", 64'(n), 64'(TO));
      chk("timeout_data", 64'(a_resp_o), 64'({32'hdeadbeef, 2'h2}));
      chk("timeout_stale_dm_ready", 64'(dm_resp_ready_o), 64'(1));
      a_resp_ready_i = 1'b1;
      tick();
      a_resp_ready_i = 1'b0;
      rr_m = 1'b1;
      b_req_i = rand_req(); b_req_valid_i = 1'b1;
      repeat (3) begin
         #1;
         chk("stale_b_ready", 64'(b_req_ready_o), 64'(0));
         chk("stale_busy", 64'(busy_o), 64'(0));
         tick();
      end
      dm_resp_valid_i = 1'b1; dm_resp_i = rand_resp();
      tick();
      dm_resp_valid_i = 1'b0;
      chk("late_resp_dropped", 64'({a_resp_valid_o, b_resp_valid_o}), 64'(0));
      chk("stale_cleared_dm_ready", 64'(dm_resp_ready_o), 64'(0));
      serve(0, 0, 0);
`else
      n = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
